// File: rtl/flappy_pkg.sv
// Shared game constants: state encoding, arithmetic widths and screen geometry.
// Used by the bird physics, renderer and pipe logic.
package flappy_pkg;

  localparam int VEL_W    = 6;
  localparam int POS_W    = 11;
  localparam int SCREEN_H = 480;
  localparam int BIRD_H   = 16;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_FLY   = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  // Clamp a one-bit-wider velocity sum to the positive fall limit.
  function automatic logic [VEL_W-1:0] sat_fall(input logic signed [VEL_W:0] v,
                                                input logic signed [VEL_W:0] lim);
    logic [VEL_W-1:0] res;
    if (v > lim) begin
      res = lim[VEL_W-1:0];
    end else begin
      res = v[VEL_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/bird_physics_param_chk.sv
// Elaboration-time guard: flap velocity and fall limit must fit the
// signed velocity register.
module bird_physics_param_chk
  import flappy_pkg::*;
#(
  parameter int FLAP_VEL = -8,
  parameter int MAX_FALL = 10
) ();

  localparam int VMIN = -(2 ** (VEL_W - 1));
  localparam int VMAX = (2 ** (VEL_W - 1)) - 1;

  if ((FLAP_VEL < VMIN) || (MAX_FALL > VMAX)) begin : g_bad_vel
    $error("bird_physics: FLAP_VEL/MAX_FALL outside signed velocity range");
  end

endmodule

// File: rtl/tick_gen.sv
// Frame tick generator: one-cycle pulse every TICK_DIV clocks, high while
// the internal count sits at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  output logic frame_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             tick_r;

  // Next count with wrap at TICK_DIV-1.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (cnt_r == LAST_C) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + ONE_C;
    end
  end

  // Counter and registered tick flag (flag tracks count == TICK_DIV-1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == LAST_C);
    end
  end

  assign frame_tick = tick_r;

endmodule

// File: rtl/bird_physics.sv
// Bird vertical motion: flap edge capture, READY/FLY/DEAD control and
// per-tick gravity/velocity/position integration with ceiling and floor.
module bird_physics
  import flappy_pkg::*;
#(
  parameter int SCREEN_H = 480,
  parameter int BIRD_H   = 16,
  parameter int START_Y  = 232,
  parameter int FLAP_VEL = -8,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 10,
  parameter int TICK_DIV = 833333
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spacebar_pressed,
  input  logic       game_over,
  output logic [9:0] bird_y,
  output logic [5:0] bird_vel,
  output logic [1:0] state,
  output logic       frame_tick
);

  localparam logic signed [VEL_W-1:0] FLAP_C  = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W:0]   GRAV_C  = (VEL_W + 1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   MAXF_C  = (VEL_W + 1)'(MAX_FALL);
  localparam logic signed [POS_W-1:0] YMAX_S  = POS_W'(SCREEN_H - BIRD_H);
  localparam logic [9:0]              YMAX_C  = 10'(SCREEN_H - BIRD_H);
  localparam logic [9:0]              START_C = 10'(START_Y);

  bird_physics_param_chk #(
    .FLAP_VEL (FLAP_VEL),
    .MAX_FALL (MAX_FALL)
  ) u_param_chk ();

  logic tick_s;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (tick_s)
  );

  state_t                    state_r, state_nxt_s;
  logic [9:0]                y_r, y_nxt_s;
  logic signed [VEL_W-1:0]   vel_r, vel_nxt_s;
  logic                      prev_r, pend_r, pend_nxt_s;

  logic                      flap_edge_s, flap_s;
  logic signed [VEL_W:0]     vel_sum_s;
  logic signed [VEL_W-1:0]   vel_new_s;
  logic signed [POS_W-1:0]   y_sum_s;
  logic [9:0]                mv_y_s;
  logic signed [VEL_W-1:0]   mv_vel_s;
  logic                      mv_floor_s;

  assign flap_edge_s = spacebar_pressed & ~prev_r;
  assign flap_s      = pend_r | flap_edge_s;

  // Candidate motion for this tick: new velocity, then clamped position.
  always_comb begin
    vel_sum_s  = $signed({vel_r[VEL_W-1], vel_r}) + GRAV_C;
    vel_new_s  = FLAP_C;
    mv_y_s     = y_r;
    mv_vel_s   = vel_r;
    mv_floor_s = 1'b0;
    if (flap_s) begin
      vel_new_s = FLAP_C;
    end else begin
      vel_new_s = sat_fall(vel_sum_s, MAXF_C);
    end
    y_sum_s = $signed({1'b0, y_r}) + $signed({{(POS_W - VEL_W){vel_new_s[VEL_W-1]}}, vel_new_s});
    if (y_sum_s < $signed(11'sd0)) begin
      mv_y_s   = 10'd0;
      mv_vel_s = {VEL_W{1'b0}};
    end else if (y_sum_s >= YMAX_S) begin
      mv_y_s     = YMAX_C;
      mv_vel_s   = {VEL_W{1'b0}};
      mv_floor_s = 1'b1;
    end else begin
      mv_y_s   = y_sum_s[9:0];
      mv_vel_s = vel_new_s;
    end
  end

  // Next-state and register updates; everything but flap capture waits for a tick.
  always_comb begin
    state_nxt_s = state_r;
    y_nxt_s     = y_r;
    vel_nxt_s   = vel_r;
    pend_nxt_s  = pend_r;
    if (tick_s) begin
      pend_nxt_s = 1'b0;
      case (state_r)
        ST_READY: begin
          if (flap_s) begin
            state_nxt_s = mv_floor_s ? ST_DEAD : ST_FLY;
            y_nxt_s     = mv_y_s;
            vel_nxt_s   = mv_vel_s;
          end else begin
            y_nxt_s   = START_C;
            vel_nxt_s = {VEL_W{1'b0}};
          end
        end
        ST_FLY: begin
          // Collision wins over both the flap and the floor clamp.
          if (game_over) begin
            state_nxt_s = ST_DEAD;
          end else begin
            state_nxt_s = mv_floor_s ? ST_DEAD : ST_FLY;
            y_nxt_s     = mv_y_s;
            vel_nxt_s   = mv_vel_s;
          end
        end
        ST_DEAD: begin
          vel_nxt_s = {VEL_W{1'b0}};
          if (flap_s) begin
            state_nxt_s = ST_READY;
            y_nxt_s     = START_C;
          end else begin
            state_nxt_s = ST_DEAD;
          end
        end
        default: begin
          state_nxt_s = ST_READY;
          y_nxt_s     = START_C;
          vel_nxt_s   = {VEL_W{1'b0}};
        end
      endcase
    end else begin
      if (flap_edge_s) begin
        pend_nxt_s = 1'b1;
      end else begin
        pend_nxt_s = pend_r;
      end
    end
  end

  // State, position, velocity and flap-capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_READY;
      y_r     <= START_C;
      vel_r   <= {VEL_W{1'b0}};
      prev_r  <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      y_r     <= y_nxt_s;
      vel_r   <= vel_nxt_s;
      prev_r  <= spacebar_pressed;
      pend_r  <= pend_nxt_s;
    end
  end

  assign bird_y     = y_r;
  assign bird_vel   = vel_r;
  assign state      = state_r;
  assign frame_tick = tick_s;

endmodule

// File: tb/tb_bird_physics.sv
// Scoreboard bench for bird_physics with a 4-cycle tick: a spec-level model
// queues expected results at each tick and compares them after the update.
module tb_bird_physics;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spacebar_pressed = 1'b0;
  logic       game_over = 1'b0;
  logic [9:0] bird_y;
  logic [5:0] bird_vel;
  logic [1:0] state;
  logic       frame_tick;

  bird_physics #(.TICK_DIV(TD)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .spacebar_pressed (spacebar_pressed),
    .game_over        (game_over),
    .bird_y           (bird_y),
    .bird_vel         (bird_vel),
    .state            (state),
    .frame_tick       (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {int y; int vel; int st;} exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int m_y, m_vel, m_st, m_cnt;
  bit m_prev, m_pend;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 232; m_vel = 0; m_st = 0; m_cnt = 0;
    m_prev = 1'b0; m_pend = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_move(input int vn);
    int yn;
    yn = m_y + vn;
    if (yn < 0) begin
      m_y = 0; m_vel = 0;
    end else if (yn >= 464) begin
      m_y = 464; m_vel = 0; m_st = 2;
    end else begin
      m_y = yn; m_vel = vn;
    end
  endtask

  task automatic check_outs(input string tag, input int y, input int v, input int st);
    check_val({tag, "_y"}, int'(bird_y), y);
    check_val({tag, "_vel"}, int'($signed(bird_vel)), v);
    check_val({tag, "_state"}, int'(state), st);
  endtask

  // One clock: drive inputs, predict, step, then compare any queued result.
  task automatic cycle(input logic sp, input logic go);
    bit   edge_b, flap_b, tick_b;
    exp_t e;
    spacebar_pressed = sp;
    game_over = go;
    edge_b = sp && !m_prev;
    flap_b = m_pend || edge_b;
    tick_b = (m_cnt == TD - 1);
    check_val("frame_tick", int'(frame_tick), int'(tick_b));
    if (tick_b) begin
      case (m_st)
        0: if (flap_b) begin m_st = 1; model_move(-8); end
        1: begin
          if (go) m_st = 2;
          else model_move(flap_b ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1));
        end
        default: begin
          if (flap_b) begin m_st = 0; m_y = 232; end
          m_vel = 0;
        end
      endcase
      e.y = m_y; e.vel = m_vel; e.st = m_st;
      sb_q.push_back(e);
    end
    m_pend = tick_b ? 1'b0 : (edge_b ? 1'b1 : m_pend);
    m_prev = sp;
    m_cnt = (m_cnt + 1) % TD;
    @(posedge clk);
    #1;
    if (tick_b) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_outs("tick", e.y, e.vel, e.st);
      end
    end
  endtask

  task automatic run_cycles(input int n, input logic sp, input logic go);
    for (int i = 0; i < n; i++) cycle(sp, go);
  endtask

  task automatic align();
    while (m_cnt != 0) cycle(1'b0, 1'b0);
  endtask

  // Aligned single-cycle press followed by exactly one tick.
  task automatic flap_once();
    align();
    cycle(1'b1, 1'b0);
    run_cycles(TD - 1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 232, 0, 0);
    check_val("reset_tick", int'(frame_tick), 0);
    reset_n = 1'b1;

    // Start: one-cycle press in READY, then first and second FLY ticks.
    flap_once();
    check_outs("start", 224, -8, 1);
    run_cycles(TD, 1'b0, 1'b0);
    check_outs("second", 217, -7, 1);

    // Free fall saturating at MAX_FALL until the floor.
    run_cycles(60 * TD, 1'b0, 1'b0);
    check_outs("floor", 464, 0, 2);

    // Restart from DEAD, then fly and keep flapping into the ceiling.
    flap_once();
    check_outs("restart", 232, 0, 0);
    for (int i = 0; i < 30; i++) flap_once();
    check_outs("ceiling", 0, 0, 1);

    // Fall a bit, then hold the key for 20 ticks.
    run_cycles(5 * TD, 1'b0, 1'b0);
    check_outs("fall5", 15, 5, 1);
    align();
    run_cycles(20 * TD, 1'b1, 1'b0);
    run_cycles(TD, 1'b0, 1'b0);

    // Press edge coinciding with tick and game_over: DEAD, flap dropped.
    while (m_cnt != TD - 1) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    run_cycles(2 * TD, 1'b1, 1'b0);
    check_val("go_dead", int'(state), 2);

    // Back to flight, then reset asynchronously mid-flight.
    flap_once();
    flap_once();
    run_cycles(TD + 2, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    check_outs("midreset", 232, 0, 0);
    check_val("midreset_tick", int'(frame_tick), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    flap_once();
    check_outs("post_reset", 224, -8, 1);
    run_cycles(3 * TD, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bird_physics.md
# bird_physics

Vertical-motion controller for the bird. Sits directly downstream of the PS/2 keyboard receiver and consumes its `spacebar_pressed` level. Each press becomes one flap impulse. On every frame tick the block integrates gravity into a signed velocity and the velocity into the bird's Y position, with ceiling and floor limits. Its outputs feed the renderer and the pipe/collision logic.

## Interface

Parameters:
- `SCREEN_H`, 480: visible lines; Y grows downward.
- `BIRD_H`, 16: bird sprite height in lines.
- `START_Y`, 232: Y position on reset and restart.
- `FLAP_VEL`, -8: signed velocity loaded by a flap, in lines per tick.
- `GRAVITY`, 1: velocity increment per tick.
- `MAX_FALL`, 10: positive velocity ceiling.
- `TICK_DIV`, 833333: clk cycles per physics tick (60 Hz at 50 MHz).

Ports:
- `clk` input 1: 50 MHz system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `spacebar_pressed` input 1: level from the keyboard block, synchronous to `clk`.
- `game_over` input 1: pipe collision flag from the collision logic, sampled on ticks.
- `bird_y` output 10: top line of the bird, range 0..`SCREEN_H`-`BIRD_H`.
- `bird_vel` output 6: signed current velocity, two's complement.
- `state` output 2: READY=0, FLY=1, DEAD=2.
- `frame_tick` output 1: one-cycle pulse, shared with the pipe scroller.

## Operation

- Edge detect: `prev` is `spacebar_pressed` registered. `flap_edge` = `spacebar_pressed` & ~`prev`.
- A `flap_edge` sets `flap_pending`. A tick clears `flap_pending`, after any use of it by that tick.
- If `flap_edge` and a tick fall in the same cycle, the flap is consumed by that tick.
- Holding the key produces exactly one flap.
- READY:
  - `bird_y` is held at `START_Y` and `bird_vel` at 0.
  - On a tick with a flap (pending or same-cycle): go to FLY, load vel=`FLAP_VEL`, and apply the position update on that same tick.
- FLY, on each tick:
  - New velocity: `FLAP_VEL` if a flap is present, otherwise min(vel+`GRAVITY`, `MAX_FALL`).
  - Then y_next = y + v_new, computed as 11-bit signed.
  - If y_next < 0: y=0 and vel=0 (ceiling bump; stay in FLY).
  - If y_next ≥ `SCREEN_H`-`BIRD_H`: y=`SCREEN_H`-`BIRD_H` and vel=0, go to DEAD.
  - If `game_over`=1 on the tick: go to DEAD and hold y and vel unchanged. This has priority over the flap and the floor checks.
- DEAD:
  - y is held and vel=0.
  - A flap on a tick → READY, with y=`START_Y` and vel=0 written on that tick.
- Arithmetic:
  - Velocity is 6-bit signed, range -32..31. Parameters must satisfy `FLAP_VEL` ≥ -32 and `MAX_FALL` ≤ 31; check with an elaboration-time assertion.
  - Position arithmetic is 11-bit signed; `bird_y` is the low 10 bits after clamping.
- Asserting `reset_n` mid-flight immediately returns every register to its reset value.

## Timing

- Reset values:
  - `bird_y`=`START_Y`, `bird_vel`=0, `state`=READY, `frame_tick`=0.
  - Tick counter=0, `prev`=0, `flap_pending`=0.
- Tick counter:
  - Counts 0..`TICK_DIV`-1, then wraps to 0.
  - `frame_tick` is high for the one cycle in which count==`TICK_DIV`-1. The first tick comes `TICK_DIV` cycles after reset release.
- `bird_y`, `bird_vel` and `state` update on the clock edge that ends the tick cycle, so they are valid from the cycle after `frame_tick`. All three outputs are registered.
- Flap latency: from `spacebar_pressed` rising to the velocity load is at most `TICK_DIV` cycles. The edge is never lost.
- `game_over` is sampled only in tick cycles.

## Structure

- Shared package `flappy_pkg` holds:
  - the state encoding constants (READY/FLY/DEAD);
  - `VEL_W`=6 and `POS_W`=11;
  - the screen constants `SCREEN_H` and `BIRD_H`, reused by the renderer and the pipe logic.
- One sub-module, `tick_gen`: parameter `TICK_DIV`, ports `clk`, `reset_n`, `frame_tick`. The pipe scroller instantiates it as well.
- The FSM and integrator stay in `bird_physics`.

## Test plan

All scenarios run with `TICK_DIV`=4 in simulation.

- Reset: hold `reset_n`=0 and pulse `clk` → `bird_y`=232, `bird_vel`=0, `state`=0, and the first `frame_tick` arrives 4 cycles after release.
- Start and flap: press space for 1 cycle in READY → next tick gives `state`=FLY, vel=-8, y=224. The following tick gives vel=-7, y=217.
- Free fall: no presses from y=224, vel=-8 → vel counts -7, -6, … up to 10, then saturates at 10 while y keeps rising by 10 per tick.
- Floor: y=460, vel=5 → y clamps to 464, vel=0, `state`=DEAD. A flap then gives READY with y=232.
- Ceiling: y=3, flap → y_next=-5, so y=0 and vel=0, still FLY.
- Simultaneous events:
  - press edge on the tick cycle together with `game_over`=1 → DEAD, and the flap is dropped;
  - press held for 20 ticks → exactly one flap.
